// File: rtl/ws2812_chain_driver.sv
// Serial driver for a chain of WS2812-style RGB LEDs: captures a frame plus brightness on start,
// emits cycle-counted high/low bit pulses, then a latch low period and a one-cycle done pulse.
module ws2812_chain_driver #(
  parameter int NUM_LEDS  = 6,
  parameter int T0H_CYC   = 10,
  parameter int T0L_CYC   = 20,
  parameter int T1H_CYC   = 20,
  parameter int T1L_CYC   = 10,
  parameter int LATCH_CYC = 1200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_LEDS*24-1:0]  pixels,
  input  logic [7:0]              brightness,
  input  logic                    blank,
  output logic                    dout,
  output logic                    busy,
  output logic                    done
);

  localparam int FRAME_W = NUM_LEDS * 24;
  localparam int MAX_H   = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
  localparam int MAX_L   = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
  localparam int MAX_HL  = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int MAX_T   = (MAX_HL > LATCH_CYC) ? MAX_HL : LATCH_CYC;
  localparam int CW      = $clog2(MAX_T) + 1;
  localparam int BW      = $clog2(FRAME_W + 1);

  localparam logic [CW-1:0] T0H_END   = CW'(T0H_CYC - 1);
  localparam logic [CW-1:0] T0L_END   = CW'(T0L_CYC - 1);
  localparam logic [CW-1:0] T1H_END   = CW'(T1H_CYC - 1);
  localparam logic [CW-1:0] T1L_END   = CW'(T1L_CYC - 1);
  localparam logic [CW-1:0] LATCH_END = CW'(LATCH_CYC - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        pulse_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [4:0]           word_bit;
  logic [23:0]          shreg;
  logic [FRAME_W-1:0]   frame_q;
  logic [7:0]           bri_q;
  logic                 pulse_end, dout_d, done_d, cur_bit;

  // Per-channel (c * (b + 1)) >> 8 as an 8x9-bit product.
  function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
    logic [8:0]  m;
    logic [16:0] p;
    logic [23:0] r;
    m = {1'b0, b} + 9'd1;
    r = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      p = {9'b0, w[ch*8 +: 8]} * {8'b0, m};
      r[ch*8 +: 8] = p[15:8];
    end
    return r;
  endfunction

  always_comb begin
    cur_bit   = shreg[23];
    pulse_end = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE:  if (start) state_d = HIGH;
      HIGH: begin
        pulse_end = (pulse_cnt == (cur_bit ? T1H_END : T0H_END));
        if (pulse_end) state_d = LOW;
      end
      LOW: begin
        pulse_end = (pulse_cnt == (cur_bit ? T1L_END : T0L_END));
        if (pulse_end) state_d = (bit_cnt == LAST_BIT) ? LATCH : HIGH;
      end
      LATCH: begin
        pulse_end = (pulse_cnt == LATCH_END);
        if (pulse_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dout_d = (state_d == HIGH) && !blank;
    done_d = (state_q == LATCH) && pulse_end;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dout      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      bit_cnt   <= '0;
      word_bit  <= '0;
      shreg     <= '0;
      frame_q   <= '0;
      bri_q     <= '0;
    end else begin
      state_q <= state_d;
      dout    <= dout_d;
      done    <= done_d;
      if (state_q == IDLE || pulse_end) pulse_cnt <= '0;
      else                              pulse_cnt <= pulse_cnt + CW'(1);
      // frame_q is kept pre-shifted so the next LED word always sits in the top 24 bits
      if (state_q == IDLE && start) begin
        frame_q  <= pixels << 24;
        bri_q    <= brightness;
        shreg    <= scale_word(pixels[FRAME_W-1 -: 24], brightness);
        bit_cnt  <= '0;
        word_bit <= '0;
      end else if (state_q == LOW && pulse_end && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + BW'(1);
        if (word_bit == 5'd23) begin
          word_bit <= '0;
          shreg    <= scale_word(frame_q[FRAME_W-1 -: 24], bri_q);
          frame_q  <= frame_q << 24;
        end else begin
          word_bit <= word_bit + 5'd1;
          shreg    <= {shreg[22:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Randomized bench for ws2812_chain_driver: decodes the serial waveform and compares it with
// frames and timing derived from an arithmetic reference model.
module tb_ws2812_chain_driver;

  localparam int NUM_LEDS = 6;
  localparam int T0H = 10, T0L = 20, T1H = 20, T1L = 10, LATCH = 1200;
  localparam int FW    = NUM_LEDS * 24;
  localparam int MAXB  = (T0H + T0L > T1H + T1L) ? T0H + T0L : T1H + T1L;
  localparam int TRACE = 2 * (FW * MAXB + LATCH) + 50;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, blank = 1'b0;
  logic [FW-1:0] pixels = '0;
  logic [7:0]    brightness = '0;
  logic          dout, busy, done;

  ws2812_chain_driver #(
    .NUM_LEDS(NUM_LEDS), .T0H_CYC(T0H), .T0L_CYC(T0L),
    .T1H_CYC(T1H), .T1L_CYC(T1L), .LATCH_CYC(LATCH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pixels(pixels), .brightness(brightness),
    .blank(blank), .dout(dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_pass = 0;
  bit          tr_dout[TRACE];
  bit          tr_busy[TRACE];
  int          done_pos[$];
  int          n_cap;
  bit          hold_start = 1'b0;
  logic [23:0] exp_w[NUM_LEDS];
  logic [23:0] dec_w[NUM_LEDS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] scale_ref(input logic [23:0] w, input int unsigned br);
    logic [23:0] r;
    int unsigned c;
    for (int ch = 0; ch < 3; ch++) begin
      c = w[ch*8 +: 8];
      r[ch*8 +: 8] = 8'((c * (br + 1)) / 256);
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int j = 0; j < NUM_LEDS; j++) f[j*24 +: 24] = 24'($urandom);
    return f;
  endfunction

  function automatic bit exp_bit(input int i);
    logic [23:0] w;
    w = exp_w[i / 24];
    return w[23 - (i % 24)];
  endfunction

  function automatic int bit_len(input int i);
    return exp_bit(i) ? T1H + T1L : T0H + T0L;
  endfunction

  function automatic int bit_start(input int i);
    int s;
    s = 1;
    for (int j = 0; j < i; j++) s += bit_len(j);
    return s;
  endfunction

  function automatic int frame_len();
    return bit_start(FW) - 1 + LATCH;
  endfunction

  task automatic start_frame(input logic [FW-1:0] px, input logic [7:0] br);
    @(negedge clk);
    pixels = px;
    brightness = br;
    start = 1'b1;
    for (int j = 0; j < NUM_LEDS; j++) exp_w[j] = scale_ref(px[FW-1-24*j -: 24], br);
  endtask

  // Samples outputs once per cycle (period n = n-th cycle after the start edge) and applies disturbances.
  task automatic run(input int max_n, input int n_dones, input int dist_at,
                     input int blk_from, input int blk_to, input int rst_at);
    done_pos.delete();
    n_cap = 0;
    for (int n = 1; n <= max_n && n < TRACE; n++) begin
      @(negedge clk);
      tr_dout[n] = dout;
      tr_busy[n] = busy;
      if (done) done_pos.push_back(n);
      n_cap = n;
      start = hold_start;
      rst_n = 1'b1;
      if (n == dist_at) begin
        pixels = rand_frame();
        brightness = 8'($urandom);
        start = 1'b1;
      end
      blank = (blk_from > 0 && n >= blk_from - 1 && n < blk_to);
      if (n == rst_at) rst_n = 1'b0;
      if (n_dones > 0 && done_pos.size() >= n_dones && n > done_pos[n_dones-1]) break;
      if (rst_at > 0 && n >= rst_at + 5) break;
    end
    start = 1'b0;
    blank = 1'b0;
    rst_n = 1'b1;
    if (n_dones > 0) check("done_seen", 64'(done_pos.size() >= n_dones), 1);
  endtask

  task automatic check_frame(input string tag, input int n0);
    int n, hi, lo, werr;
    bit b;
    n = n0;
    werr = 0;
    for (int i = 0; i < FW; i++) begin
      hi = 0;
      lo = 0;
      while (n <= n_cap && tr_dout[n]) begin hi++; n++; end
      while (n <= n_cap && !tr_dout[n] && lo < LATCH + MAXB) begin lo++; n++; end
      b = (hi > (T0H + T1H) / 2);
      dec_w[i / 24][23 - (i % 24)] = b;
      if (hi != (exp_bit(i) ? T1H : T0H)) werr++;
      if (i < FW - 1 && lo != (exp_bit(i) ? T1L : T0L)) werr++;
    end
    for (int j = 0; j < NUM_LEDS; j++) check($sformatf("%s_led%0d", tag, j), dec_w[j], exp_w[j]);
    check({tag, "_pulse_widths"}, werr, 0);
  endtask

  task automatic check_timing(input string tag);
    int nl, bad;
    nl = frame_len();
    bad = 0;
    check({tag, "_done_count"}, done_pos.size(), 1);
    check({tag, "_done_cycle"}, (done_pos.size() > 0) ? done_pos[0] : -1, nl + 1);
    if (n_cap < nl + 1) bad++;
    else begin
      for (int n = 1; n <= nl; n++) if (!tr_busy[n]) bad++;
      if (tr_busy[nl + 1]) bad++;
    end
    check({tag, "_busy"}, bad, 0);
  endtask

  initial begin
    logic [FW-1:0] px;
    int nl, bf, bt, ra, hits;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      start_frame(rand_frame(), (t == 0) ? 8'd255 : 8'($urandom));
      run(frame_len() + 10, 1, -1, -1, -1, -1);
      check_frame($sformatf("rand%0d", t), 1);
      check_timing($sformatf("rand%0d", t));
    end

    px = rand_frame();
    px[FW-1 -: 24] = 24'hFF8001;
    start_frame(px, 8'd127);
    run(frame_len() + 10, 1, -1, -1, -1, -1);
    check_frame("bri127", 1);
    check("bri127_literal", dec_w[0], 24'h7F4000);

    start_frame(rand_frame(), 8'd0);
    run(frame_len() + 10, 1, -1, -1, -1, -1);
    check_frame("bri0", 1);
    check_timing("bri0");

    start_frame(rand_frame(), 8'($urandom));
    run(frame_len() + 10, 1, 1000, -1, -1, -1);
    check_frame("midchg", 1);
    check_timing("midchg");

    start_frame(rand_frame(), 8'd255);
    bf = bit_start(10);
    bt = bit_start(41) - 1;
    run(frame_len() + 10, 1, -1, bf, bt, -1);
    hits = 0;
    for (int n = bf; n <= bt; n++) if (tr_dout[n]) hits++;
    check("blank_window_high", hits, 0);
    check("blank_release", tr_dout[bt + 1], 1);
    check_timing("blank");

    start_frame(rand_frame(), 8'($urandom));
    ra = bit_start(80) + 3;
    run(ra + 10, 0, -1, -1, -1, ra);
    check("rst_mid_busy_before", tr_busy[ra], 1);
    check("rst_mid_dout", tr_dout[ra + 1], 0);
    check("rst_mid_busy", tr_busy[ra + 1], 0);
    check("rst_mid_no_done", done_pos.size(), 0);
    start_frame(rand_frame(), 8'($urandom));
    run(frame_len() + 10, 1, -1, -1, -1, -1);
    check_frame("post_rst", 1);
    check_timing("post_rst");

    hold_start = 1'b1;
    start_frame(rand_frame(), 8'($urandom));
    nl = frame_len();
    run(2 * nl + 20, 2, -1, -1, -1, -1);
    hold_start = 1'b0;
    check_frame("b2b", 1);
    check("b2b_done0", (done_pos.size() > 0) ? done_pos[0] : -1, nl + 1);
    check("b2b_done1", (done_pos.size() > 1) ? done_pos[1] : -1, 2 * nl + 2);
    check("b2b_restart0", tr_dout[nl + 2], 1);
    check("b2b_restart1", tr_dout[2 * nl + 3], 1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
